dbuf_filt: RTL and testbench



---
 rtl/dbuf_filt.sv | 106 ++++++++++
 tb/tb_dbuf_filt.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbuf_filt.sv
// Multi-channel input synchroniser + saturating-counter deglitch filter with rise/fall pulses.
// Optional sticky change flags (clr/chg) are built when DBUF_FILT_STICKY_EN is defined.
module dbuf_filt #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned DEGLITCH    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_VAL     = 0
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           SUB,
    input  logic           en,
    input  logic [NCH-1:0] byp,
    input  logic [NCH-1:0] i,
`ifdef DBUF_FILT_STICKY_EN
    input  logic           clr,
    output logic [NCH-1:0] chg,
`endif
    output logic [NCH-1:0] o,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall
);

    localparam int unsigned    CW       = $clog2(DEGLITCH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEGLITCH - 1);
    localparam logic [NCH-1:0] RST_VEC  = {NCH{1'(RST_VAL)}};

    logic [NCH-1:0] sync [SYNC_STAGES];
    logic [CW-1:0]  cnt [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic [NCH-1:0] s;
    logic [NCH-1:0] o_nxt;
    logic           unused_pins;

    // Supply/substrate pins are pass-through only.
    assign unused_pins = ^{CELV, CELG, SUB};

    assign s = sync[SYNC_STAGES-1];

    // Synchroniser chain runs regardless of en.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync[j] <= RST_VEC;
            end
        end else begin
            sync[0] <= i;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync[j] <= sync[j-1];
            end
        end
    end

    // Per-channel filter decision; everything holds while en=0.
    always_comb begin
        o_nxt = o;
        for (int k = 0; k < NCH; k++) begin
            cnt_nxt[k] = cnt[k];
            if (en) begin
                if (byp[k]) begin
                    o_nxt[k]   = s[k];
                    cnt_nxt[k] = '0;
                end else if (s[k] == o[k]) begin
                    cnt_nxt[k] = '0;
                end else if (cnt[k] == CNT_LAST) begin
                    o_nxt[k]   = s[k];
                    cnt_nxt[k] = '0;
                end else begin
                    cnt_nxt[k] = cnt[k] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            o    <= RST_VEC;
            rise <= '0;
            fall <= '0;
            for (int k = 0; k < NCH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            o    <= o_nxt;
            rise <= o_nxt & ~o;
            fall <= ~o_nxt & o;
            for (int k = 0; k < NCH; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
        end
    end

`ifdef DBUF_FILT_STICKY_EN
    // Sticky change flags: a pulse in the same cycle as clr wins.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            chg <= '0;
        end else begin
            chg <= (chg & ~{NCH{clr}}) | rise | fall;
        end
    end
`endif

endmodule

// File: tb/tb_dbuf_filt.sv
// Self-checking bench for dbuf_filt: directed scenarios plus randomized traffic vs a behavioural model.
module tb_dbuf_filt;

    localparam int unsigned NCH         = 4;
    localparam int unsigned DEGLITCH    = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned RST_VAL     = 0;

    logic           clk = 1'b0;
    logic           rstb;
    logic           en;
    logic [NCH-1:0] byp;
    logic [NCH-1:0] i;
    logic           clr;
    logic [NCH-1:0] o;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
`ifdef DBUF_FILT_STICKY_EN
    logic [NCH-1:0] chg;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit [NCH-1:0] m_sync [SYNC_STAGES];
    bit [NCH-1:0] m_o;
    bit [NCH-1:0] m_rise;
    bit [NCH-1:0] m_fall;
    bit [NCH-1:0] m_chg;
    int           m_cnt [NCH];

    dbuf_filt #(
        .NCH(NCH), .DEGLITCH(DEGLITCH), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(RST_VAL)
    ) dut (
        .clk(clk), .rstb(rstb), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en(en), .byp(byp), .i(i),
`ifdef DBUF_FILT_STICKY_EN
        .clr(clr), .chg(chg),
`endif
        .o(o), .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;

    // Model: output follows the synchronised level once it has differed for DEGLITCH enabled edges.
    task automatic model_edge();
        bit [NCH-1:0] s;
        bit [NCH-1:0] nxt;
        if (!rstb) begin
            for (int j = 0; j < SYNC_STAGES; j++) m_sync[j] = {NCH{1'(RST_VAL)}};
            for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
            m_o = {NCH{1'(RST_VAL)}};
            m_rise = '0;
            m_fall = '0;
            m_chg = '0;
        end else begin
            s = m_sync[SYNC_STAGES-1];
            nxt = m_o;
            m_chg = (m_chg & ~{NCH{clr}}) | m_rise | m_fall;
            for (int k = 0; k < NCH; k++) begin
                if (en) begin
                    if (byp[k]) begin
                        nxt[k] = s[k];
                        m_cnt[k] = 0;
                    end else if (s[k] == m_o[k]) begin
                        m_cnt[k] = 0;
                    end else if (m_cnt[k] + 1 >= int'(DEGLITCH)) begin
                        nxt[k] = s[k];
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
            m_rise = nxt & ~m_o;
            m_fall = ~nxt & m_o;
            m_o = nxt;
            for (int j = SYNC_STAGES - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
            m_sync[0] = i;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; en = 1'b1; byp = '0; i = '0; clr = 1'b0;
        step();
        step();
        checks++;
        if (o !== 4'b0000) begin failures++; $display("FAIL reset_o got=%b exp=0000", o); end
        checks++;
        if ({rise, fall} !== 8'h00) begin failures++; $display("FAIL reset_pulses got=%b/%b exp=0/0", rise, fall); end
        checks++;
        if ({o, rise, fall} !== {m_o, m_rise, m_fall}) begin
            failures++; $display("FAIL reset_model got=%b/%b/%b exp=%b/%b/%b", o, rise, fall, m_o, m_rise, m_fall);
        end
        rstb = 1'b1;
    endtask

    task automatic test_step_ch0();
        int first = -1;
        int nrise = 0;
        int upper = 0;
        i = 4'b0001;
        for (int n = 1; n <= 14; n++) begin
            step();
            checks++;
            if ({o, rise, fall} !== {m_o, m_rise, m_fall}) begin
                failures++; $display("FAIL step0 n=%0d got=%b/%b/%b exp=%b/%b/%b", n, o, rise, fall, m_o, m_rise, m_fall);
            end
            if (o[0] && first < 0) first = n;
            nrise += int'(rise[0]);
            upper += int'(|o[3:1]);
        end
        checks++;
        if (first != int'(SYNC_STAGES + DEGLITCH)) begin failures++; $display("FAIL step0_latency got=%0d exp=%0d", first, SYNC_STAGES + DEGLITCH); end
        checks++;
        if (nrise != 1) begin failures++; $display("FAIL step0_rise_count got=%0d exp=1", nrise); end
        checks++;
        if (upper != 0) begin failures++; $display("FAIL step0_other_ch got=%0d exp=0", upper); end
    endtask

    task automatic test_glitch_ch1();
        int saw = 0;
        int first = -1;
        i[1] = 1'b1;
        for (int n = 0; n < 13; n++) begin
            if (n == 5) i[1] = 1'b0;
            step();
            checks++;
            if ({o, rise, fall} !== {m_o, m_rise, m_fall}) begin
                failures++; $display("FAIL glitch n=%0d got=%b/%b/%b exp=%b/%b/%b", n, o, rise, fall, m_o, m_rise, m_fall);
            end
            saw += int'(rise[1] | o[1]);
        end
        checks++;
        if (saw != 0) begin failures++; $display("FAIL glitch_passed got=%0d exp=0", saw); end
        i[1] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (o[1] && first < 0) first = n;
        end
        checks++;
        if (first != int'(SYNC_STAGES + DEGLITCH)) begin failures++; $display("FAIL glitch_hold_latency got=%0d exp=%0d", first, SYNC_STAGES + DEGLITCH); end
    endtask

    task automatic test_bypass();
        int first = -1;
        int pulses = 0;
        byp = 4'b0100;
        for (int t = 0; t < 24; t++) begin
            if (t % 4 == 0) i[2] = ~i[2];
            step();
            checks++;
            if ({o, rise, fall} !== {m_o, m_rise, m_fall}) begin
                failures++; $display("FAIL bypass t=%0d got=%b/%b/%b exp=%b/%b/%b", t, o, rise, fall, m_o, m_rise, m_fall);
            end
            if (o[2] && first < 0) first = t + 1;
            pulses += int'(rise[2]) + int'(fall[2]);
        end
        checks++;
        if (first != int'(SYNC_STAGES + 1)) begin failures++; $display("FAIL bypass_latency got=%0d exp=%0d", first, SYNC_STAGES + 1); end
        checks++;
        if (pulses != 6) begin failures++; $display("FAIL bypass_pulses got=%0d exp=6", pulses); end
        byp = '0;
    endtask

    task automatic test_enable_hold();
        int pulses = 0;
        int first = -1;
        i[3] = 1'b1;
        for (int n = 0; n < 4; n++) step();
        en = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            pulses += int'(|rise) + int'(|fall);
            checks++;
            if ({o, rise, fall} !== {m_o, m_rise, m_fall}) begin
                failures++; $display("FAIL en_off n=%0d got=%b/%b/%b exp=%b/%b/%b", n, o, rise, fall, m_o, m_rise, m_fall);
            end
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL en_off_pulses got=%0d exp=0", pulses); end
        en = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (o[3] && first < 0) first = n;
        end
        checks++;
        if (first != int'(DEGLITCH - (4 - SYNC_STAGES))) begin
            failures++; $display("FAIL en_resume_latency got=%0d exp=%0d", first, DEGLITCH - (4 - SYNC_STAGES));
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        int bad = 0;
        i[0] = 1'b0;
        for (int n = 0; n < 20 && !reached; n++) begin
            step();
            if (m_cnt[0] == 6 && m_o[0]) reached = 1'b1;
        end
        checks++;
        if (!reached || o[0] !== 1'b1) begin failures++; $display("FAIL midreset_setup got=%b exp=1", o[0]); end
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        checks++;
        if ({o, rise, fall} !== 12'h000) begin failures++; $display("FAIL midreset_state got=%b/%b/%b exp=0/0/0", o, rise, fall); end
        for (int n = 0; n < 14; n++) begin
            step();
            bad += int'(o[0] | rise[0] | fall[0]);
            checks++;
            if ({o, rise, fall} !== {m_o, m_rise, m_fall}) begin
                failures++; $display("FAIL midreset_after n=%0d got=%b/%b/%b exp=%b/%b/%b", n, o, rise, fall, m_o, m_rise, m_fall);
            end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL midreset_ch0_stays got=%0d exp=0", bad); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rstb = ($urandom % 150) != 0;
            en   = ($urandom % 8) != 0;
            if ($urandom % 40 == 0) byp = NCH'($urandom);
            for (int k = 0; k < NCH; k++) if ($urandom % 7 == 0) i[k] = ~i[k];
            clr  = ($urandom % 5) == 0;
            step();
            checks++;
            if ({o, rise, fall} !== {m_o, m_rise, m_fall}) begin
                failures++; $display("FAIL random n=%0d got=%b/%b/%b exp=%b/%b/%b", n, o, rise, fall, m_o, m_rise, m_fall);
            end
            checks++;
            if ((rise & fall) !== '0) begin failures++; $display("FAIL random_both n=%0d rise=%b fall=%b exp no overlap", n, rise, fall); end
`ifdef DBUF_FILT_STICKY_EN
            checks++;
            if (chg !== m_chg) begin failures++; $display("FAIL random_chg n=%0d got=%b exp=%b", n, chg, m_chg); end
`endif
        end
        rstb = 1'b1; en = 1'b1; byp = '0; clr = 1'b0;
    endtask

`ifdef DBUF_FILT_STICKY_EN
    task automatic test_sticky();
        bit seen;
        rstb = 1'b0; i = 4'b0001; clr = 1'b0;
        step();
        rstb = 1'b1;
        for (int n = 0; n < 12; n++) step();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        i[0] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin step(); seen = fall[0]; end
        step();
        checks++;
        if (chg[0] !== 1'b1 || !seen) begin failures++; $display("FAIL sticky_fall got=%b exp=1", chg[0]); end
        i[0] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin step(); seen = rise[0]; end
        clr = 1'b1;
        step();
        checks++;
        if (chg[0] !== 1'b1 || !seen) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", chg[0]); end
        clr = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (chg[0] !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", chg[0]); end
        checks++;
        if (chg !== m_chg) begin failures++; $display("FAIL sticky_model got=%b exp=%b", chg, m_chg); end
    endtask
`endif

    initial begin
        test_reset();
        test_step_ch0();
        test_glitch_ch1();
        test_bypass();
        test_enable_hold();
        test_reset_mid();
        test_random();
`ifdef DBUF_FILT_STICKY_EN
        test_sticky();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
